// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, instruction field layout
// and the fetch FSM state encoding.
package cpu_pkg;

  localparam int INSTR_W   = 16;
  localparam int FIELD_W   = 4;
  localparam int BUF_DEPTH = 2;

  localparam int OP_LSB  = 12;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 4;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LSL = 4'h3;
  localparam logic [3:0] OP_LSR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_BE  = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_BLT = 4'hD;
  localparam logic [3:0] OP_BGT = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [FIELD_W-1:0] instr_field(input logic [INSTR_W-1:0] word,
                                                     input int lsb);
    logic [INSTR_W-1:0] shifted;
    shifted = word >> lsb;
    return shifted[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/instr_buffer.sv
// Two-entry FIFO of fetched instruction words, each tagged with its fetch address.
module instr_buffer
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] word_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               pop_i,
  output logic [INSTR_W-1:0] head_word_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [1:0]         count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [INSTR_W-1:0] word_q [BUF_DEPTH];
  logic [ADDR_W-1:0]  pc_q   [BUF_DEPTH];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push_s, do_pop_s;

  assign full_o      = (count_q == 2'd2);
  assign empty_o     = (count_q == 2'd0);
  assign count_o     = count_q;
  assign head_word_o = word_q[rd_ptr_q];
  assign head_pc_o   = pc_q[rd_ptr_q];
  assign do_push_s   = push_i & ~full_o & ~flush_i;
  assign do_pop_s    = pop_i & ~empty_o;

  // Flush wins over any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      rd_ptr_d = rd_ptr_q ^ do_pop_s;
      wr_ptr_d = wr_ptr_q ^ do_push_s;
      count_d  = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        word_q[i] <= {INSTR_W{1'b0}};
        pc_q[i]   <= RESET_PC;
      end
    end else if (do_push_s) begin
      word_q[wr_ptr_q] <= word_i;
      pc_q[wr_ptr_q]   <= pc_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and issue: owns the fetch PC, runs the memory request FSM and
// presents the head of the prefetch buffer split into instruction fields.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [FIELD_W-1:0] op,
  output logic [FIELD_W-1:0] ra,
  output logic [FIELD_W-1:0] rb,
  output logic [FIELD_W-1:0] imm4,
  output logic [ADDR_W-1:0]  pc,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target
);

  fetch_state_e       state_q;
  logic               imem_req_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic [ADDR_W-1:0]  fetch_pc_q;

  logic               ack_s, push_s, pop_s, room_s;
  logic [ADDR_W-1:0]  redirect_pc_s, after_ack_pc_s;
  logic [INSTR_W-1:0] head_word_s;
  logic [ADDR_W-1:0]  head_pc_s;
  logic [1:0]         count_s;
  logic               full_s, empty_s;

  assign ack_s          = imem_req_q & imem_ack;
  assign pop_s          = ~empty_s & instr_ready;
  assign push_s         = (state_q == FS_FETCH) & ack_s & ~branch_en;
  assign redirect_pc_s  = branch_en ? branch_target : fetch_pc_q;
  assign after_ack_pc_s = branch_en ? branch_target
                                    : fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // A redirect empties the buffer, so it always leaves room for the next request.
  always_comb begin
    room_s = 1'b0;
    if (branch_en) begin
      room_s = 1'b1;
    end else if (push_s) begin
      room_s = (count_s == 2'd0) || ((count_s == 2'd1) && pop_s);
    end else begin
      room_s = ~full_s || pop_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FS_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
    end else begin
      case (state_q)
        FS_IDLE: begin
          fetch_pc_q <= redirect_pc_s;
          if (en && room_s) begin
            state_q     <= FS_FETCH;
            imem_req_q  <= 1'b1;
            imem_addr_q <= redirect_pc_s;
          end else begin
            state_q    <= FS_IDLE;
            imem_req_q <= 1'b0;
          end
        end
        FS_FETCH: begin
          if (ack_s) begin
            fetch_pc_q <= after_ack_pc_s;
            if (en && room_s) begin
              state_q     <= FS_FETCH;
              imem_req_q  <= 1'b1;
              imem_addr_q <= after_ack_pc_s;
            end else begin
              state_q    <= FS_IDLE;
              imem_req_q <= 1'b0;
            end
          end else if (branch_en) begin
            // Request stays up at the old address; its data is thrown away in DROP.
            state_q    <= FS_DROP;
            fetch_pc_q <= branch_target;
          end else begin
            state_q <= FS_FETCH;
          end
        end
        FS_DROP: begin
          fetch_pc_q <= redirect_pc_s;
          if (ack_s) begin
            if (en && room_s) begin
              state_q     <= FS_FETCH;
              imem_req_q  <= 1'b1;
              imem_addr_q <= redirect_pc_s;
            end else begin
              state_q    <= FS_IDLE;
              imem_req_q <= 1'b0;
            end
          end else begin
            state_q <= FS_DROP;
          end
        end
        default: begin
          state_q    <= FS_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  instr_buffer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (branch_en),
    .push_i      (push_s),
    .word_i      (imem_rdata),
    .pc_i        (imem_addr_q),
    .pop_i       (pop_s),
    .head_word_o (head_word_s),
    .head_pc_o   (head_pc_s),
    .count_o     (count_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = ~empty_s;
  assign pc          = head_pc_s;
  assign op          = instr_field(head_word_s, OP_LSB);
  assign ra          = instr_field(head_word_s, RA_LSB);
  assign rb          = instr_field(head_word_s, RB_LSB);
  assign imm4        = instr_field(head_word_s, IMM_LSB);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, expected issue stream
// derived from program order and redirects, and a monitor that scores every transfer.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, en, imem_req, imem_ack, instr_valid, instr_ready, branch_en;
  logic [15:0] imem_addr, imem_rdata, pc, branch_target;
  logic [3:0]  op, ra, rb, imm4;

  int          total = 0;
  int          bad = 0;
  int          n_issued = 0;
  logic [15:0] last_pc = 16'h0000;
  int          mem_lat = 0;
  int          mem_cnt = 0;
  bit          mem_force = 1'b0;
  logic [31:0] exp_q[$];

  fetch_unit #(.ADDR_W(16), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .ra(ra), .rb(rb), .imm4(imm4), .pc(pc),
    .branch_en(branch_en), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    else if (a == 16'h0001) return 16'hA5F0;
    else return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Program order from a start address: the stream the consumer must see next.
  task automatic set_stream(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [15:0] a;
      a = start + 16'(i);
      exp_q.push_back({mem_word(a), a});
    end
  endtask

  task automatic do_reset(input bit en_v, input bit rdy_v);
    reset = 1'b0; en = 1'b0; branch_en = 1'b0; instr_ready = 1'b0; mem_force = 1'b0;
    branch_target = 16'h0000;
    tick(2);
    check("rst_req_addr", 32'({imem_req, imem_addr}), 32'({1'b0, RESET_PC}));
    check("rst_valid_pc", 32'({instr_valid, pc}), 32'({1'b0, RESET_PC}));
    check("rst_fields", 32'({op, ra, rb, imm4}), 32'h0);
    set_stream(RESET_PC);
    en = en_v; instr_ready = rdy_v;
    reset = 1'b1;
  endtask

  // Memory: acks after mem_lat wait cycles, or forces ack high on request.
  initial begin
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (mem_force) begin
        imem_ack = 1'b1; imem_rdata = 16'hDEAD; mem_cnt = 0;
      end else if (!imem_req) begin
        imem_ack = 1'b0; mem_cnt = 0;
      end else if (mem_cnt >= mem_lat) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); mem_cnt = 0;
      end else begin
        imem_ack = 1'b0; mem_cnt++;
      end
    end
  end

  // Scores every transfer against the head of the expected stream.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_unexpected: actual pc=%0h required=none", pc);
        end else begin
          e = exp_q.pop_front();
          check("issue_pc", 32'(pc), 32'(e[15:0]));
          check("issue_fields", 32'({op, ra, rb, imm4}), 32'(e[31:16]));
        end
        n_issued++;
        last_pc = pc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cnt;
    bit found, vseen;
    reset = 1'b0; en = 1'b0; instr_ready = 1'b0; branch_en = 1'b0; branch_target = 16'h0000;

    // Reset then run with zero-wait memory.
    mem_lat = 0; do_reset(1'b1, 1'b1);
    tick(1); check("s1_req_a0", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));
    tick(1); check("s1_req_a1", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0001}));
    tick(1); check("s1_req_a2", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0002}));
    n0 = n_issued; tick(8);
    check("s1_throughput", 32'(n_issued - n0), 32'd8);

    // Back-pressure: buffer fills, requests stop, then drain and resume.
    do_reset(1'b1, 1'b0);
    tick(3);
    check("s2_req_dropped", 32'(imem_req), 32'd0);
    check("s2_head", 32'({instr_valid, pc}), 32'({1'b1, 16'h0000}));
    n0 = n_issued; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (imem_req) cnt++;
    end
    check("s2_no_req", 32'(cnt), 32'd0);
    check("s2_no_issue", 32'(n_issued - n0), 32'd0);
    instr_ready = 1'b1;
    tick(1); check("s2_resume_a2", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0002}));
    tick(3); check("s2_drained", 32'(n_issued - n0), 32'd4);

    // Redirect while a slow request is outstanding.
    mem_lat = 3; do_reset(1'b1, 1'b1);
    tick(1); check("s3_req_a0", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));
    branch_target = 16'h0040; branch_en = 1'b1;
    tick(1); branch_en = 1'b0; set_stream(16'h0040);
    check("s3_valid_after_branch", 32'(instr_valid), 32'd0);
    found = 1'b0; vseen = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (instr_valid) vseen = 1'b1;
      if (imem_req && imem_addr != 16'h0000) found = 1'b1;
    end
    check("s3_new_req_seen", 32'(found), 32'd1);
    check("s3_new_req_addr", 32'(imem_addr), 32'h0040);
    check("s3_squashed_not_valid", 32'(vseen), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (instr_valid) found = 1'b1;
    end
    check("s3_first_issue", 32'({found, pc}), 32'({1'b1, 16'h0040}));

    // Redirect in the same cycle as the head transfer.
    mem_lat = 0; do_reset(1'b1, 1'b0);
    branch_target = 16'h0005; branch_en = 1'b1;
    tick(1); branch_en = 1'b0; set_stream(16'h0005);
    tick(4);
    check("s4_head5", 32'({instr_valid, pc}), 32'({1'b1, 16'h0005}));
    check("s4_full_no_req", 32'(imem_req), 32'd0);
    n0 = n_issued;
    instr_ready = 1'b1; branch_target = 16'h0009; branch_en = 1'b1;
    tick(1); branch_en = 1'b0; set_stream(16'h0009);
    check("s4_pc5_consumed", 32'(n_issued - n0), 32'd1);
    check("s4_valid_flushed", 32'(instr_valid), 32'd0);
    tick(1);
    check("s4_target_valid", 32'({instr_valid, pc}), 32'({1'b1, 16'h0009}));
    tick(3);

    // Wrap-around and enable drop during a wait state.
    mem_lat = 1; do_reset(1'b1, 1'b1);
    n0 = n_issued;
    branch_target = 16'hFFFF; branch_en = 1'b1;
    tick(1); branch_en = 1'b0; set_stream(16'hFFFF);
    check("s5_req_ffff", 32'({imem_req, imem_addr}), 32'({1'b1, 16'hFFFF}));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (imem_req && imem_addr == 16'h0000) found = 1'b1;
    end
    check("s5_wrap_req", 32'(found), 32'd1);
    en = 1'b0;
    tick(2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) cnt++;
      tick(1);
    end
    check("s5_no_req_en_low", 32'(cnt), 32'd0);
    check("s5_issued", 32'(n_issued - n0), 32'd2);
    check("s5_last_pc", 32'(last_pc), 32'h0000);

    // Asynchronous reset during an outstanding fetch, with ack raised in reset.
    mem_lat = 5; do_reset(1'b1, 1'b1);
    tick(2);
    check("s6_req_before", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));
    #2; reset = 1'b0; #1;
    check("s6_async_req_addr", 32'({imem_req, imem_addr}), 32'({1'b0, RESET_PC}));
    check("s6_async_valid_pc", 32'({instr_valid, pc}), 32'({1'b0, RESET_PC}));
    mem_force = 1'b1;
    tick(2);
    check("s6_ack_ignored", 32'({imem_req, instr_valid}), 32'd0);
    set_stream(RESET_PC);
    @(negedge clk); mem_force = 1'b0; reset = 1'b1;
    tick(1);
    check("s6_first_req", 32'({imem_req, imem_addr}), 32'({1'b1, RESET_PC}));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (instr_valid) found = 1'b1;
    end
    check("s6_first_issue", 32'({found, pc}), 32'({1'b1, RESET_PC}));
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
